// File: rtl/enc_dec_pkg.sv
// Shared types and defaults for the packer, encryptor and decryptor.
// Frame geometry and FSM state encoding live here.
package enc_dec_pkg;

    typedef logic [7:0] byte_t;

    localparam int    DEF_MSG_LEN  = 22;
    localparam byte_t DEF_PAD_CHAR = 8'h20;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/msg_frame_packer.sv
// Packs a valid/ready byte stream into fixed-size, space-padded frames.
// A frame is held stable until the consumer takes it.
module msg_frame_packer
    import enc_dec_pkg::*;
#(
    parameter int    MSG_LEN  = DEF_MSG_LEN,
    parameter byte_t PAD_CHAR = DEF_PAD_CHAR,
    localparam int   LW       = $clog2(MSG_LEN + 1),
    localparam int   IW       = $clog2(MSG_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  byte_t         in_byte,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output byte_t         frame_out [0:MSG_LEN-1],
    output logic [LW-1:0] frame_len,
    output logic          frame_last,
    output logic          frame_valid,
    input  logic          frame_ready
);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] wr_idx;
    logic          accept;
    logic          close;
    logic          drain;
    logic          at_end;

    assign at_end = (wr_idx == IW'(MSG_LEN - 1));

    // Next-state and handshake decode from the registered state.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        accept      = 1'b0;
        close       = 1'b0;
        drain       = 1'b0;
        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                close    = in_valid & (at_end | in_last);
                if (close) state_d = HOLD;
            end
            HOLD: begin
                frame_valid = 1'b1;
                drain       = frame_ready;
                if (frame_ready) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Byte buffer, write index, length and last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) frame_out[i] <= PAD_CHAR;
            wr_idx     <= '0;
            frame_len  <= '0;
            frame_last <= 1'b0;
        end else if (drain) begin
            for (int i = 0; i < MSG_LEN; i++) frame_out[i] <= PAD_CHAR;
            wr_idx     <= '0;
            frame_len  <= '0;
            frame_last <= 1'b0;
        end else if (accept) begin
            frame_out[wr_idx] <= in_byte;
            frame_len         <= frame_len + LW'(1);
            // Index parks on the last slot it wrote when the frame closes.
            if (!close) wr_idx <= wr_idx + IW'(1);
            if (close) frame_last <= in_last;
        end
    end

endmodule

// File: tb/tb_msg_frame_packer.sv
// Directed self-checking bench for msg_frame_packer.
// Frames are checked byte by byte against the stimulus strings.
module tb_msg_frame_packer;
    import enc_dec_pkg::*;

    localparam int ML = 22;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    byte_t         in_byte = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    byte_t         frame_out [0:ML-1];
    logic [LW-1:0] frame_len;
    logic          frame_last;
    logic          frame_valid;
    logic          frame_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int frames_seen = 0;

    msg_frame_packer #(.MSG_LEN(ML), .PAD_CHAR(8'h20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .frame_out   (frame_out),
        .frame_len   (frame_len),
        .frame_last  (frame_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && frame_valid && frame_ready) frames_seen++;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input byte_t b, input logic l);
        int n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic l);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], l && (i == s.len() - 1));
    endtask

    task automatic check_frame(input string tag, input string s,
                               input logic exp_last);
        byte_t e;
        chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
        chk({tag, "_len"}, 32'(frame_len), 32'(s.len()));
        chk({tag, "_last"}, 32'(frame_last), 32'(exp_last));
        for (int i = 0; i < ML; i++) begin
            e = (i < s.len()) ? s[i] : 8'h20;
            chk($sformatf("%s_b%0d", tag, i), 32'(frame_out[i]), 32'(e));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_fvalid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_flen"}, 32'(frame_len), 32'd0);
        chk({tag, "_flast"}, 32'(frame_last), 32'd0);
        for (int i = 0; i < ML; i++)
            chk($sformatf("%s_pad%0d", tag, i), 32'(frame_out[i]), 32'h20);
    endtask

    initial begin
        string s;
        int f0;

        // 1 reset
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_rel");

        // 2 short message
        send_str("HELLO", 1'b1);
        check_frame("hello", "HELLO", 1'b1);
        @(posedge clk); #1;
        chk("hello_drain", 32'(frame_valid), 32'd0);
        chk("hello_clr", 32'(frame_out[0]), 32'h20);

        // 3 exactly one full frame with last
        f0 = frames_seen;
        send_str("HELLOTHISISATESTMESSAG", 1'b1);
        check_frame("full", "HELLOTHISISATESTMESSAG", 1'b1);
        @(posedge clk); #1;
        chk("full_nframes", 32'(frames_seen - f0), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd1);

        // 4 split across two frames
        f0 = frames_seen;
        s = "";
        for (int i = 0; i < 25; i++) s = {s, string'(8'h41 + 8'(i))};
        for (int i = 0; i < 22; i++) send_byte(s[i], 1'b0);
        check_frame("split1", s.substr(0, 21), 1'b0);
        for (int i = 22; i < 25; i++) send_byte(s[i], i == 24);
        check_frame("split2", s.substr(22, 24), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("split_nframes", 32'(frames_seen - f0), 32'd2);

        // 5 backpressure
        frame_ready = 1'b0;
        send_str("AB", 1'b1);
        in_byte  = "Z";
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid%0d", c), 32'(frame_valid), 32'd1);
            chk($sformatf("bp_rdy%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_len%0d", c), 32'(frame_len), 32'd2);
            chk($sformatf("bp_b0_%0d", c), 32'(frame_out[0]), 32'h41);
            chk($sformatf("bp_b1_%0d", c), 32'(frame_out[1]), 32'h42);
            chk($sformatf("bp_b2_%0d", c), 32'(frame_out[2]), 32'h20);
        end
        frame_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_fill_rdy", 32'(in_ready), 32'd1);
        chk("bp_fill_len", 32'(frame_len), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_frame("bp_next", "Z", 1'b1);
        @(posedge clk); #1;

        // 6 reset mid-fill
        send_str("ABCDEFG", 1'b0);
        chk("mid_len", 32'(frame_len), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_str("HI", 1'b1);
        check_frame("hi", "HI", 1'b1);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
